// File: rtl/mmio_uart_periph_if.sv
// CPU memory-bus port bundle for the UART/LED/button peripheral window.
// Latency: none in the bundle itself; the slave registers mem_rdata one cycle after the request.
// Backpressure: none, the bus is always accepted; mem_rdata is 0 for non-selected cycles.
interface mmio_uart_periph_if;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mmio_uart_periph.sv
// Memory-mapped UART data/status, LED, button and IRQ-enable window with RX/TX FIFOs.
// Latency: read data one cycle after request; TX byte leaves one cycle after it is at the head.
// Backpressure: full FIFOs drop bytes and set sticky overflow flags; TX drains only while tx_RDY.
module mmio_uart_periph #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          LED_W      = 8,
    parameter int          BTN_W      = 6
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    mmio_uart_periph_if.slave    bus,
    output logic [7:0]           tx_D,
    output logic                 tx_EN,
    input  logic                 tx_RDY,
    input  logic [7:0]           rx_D,
    input  logic                 rx_EN,
    input  logic                 rx_ERR,
    input  logic [BTN_W-1:0]     btn,
    output logic [LED_W-1:0]     led,
    output logic                 irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    // RX entries carry the framing-error bit above the data byte
    logic [8:0]       rx_mem [FIFO_DEPTH];
    logic [7:0]       tx_mem [FIFO_DEPTH];
    logic [AW-1:0]    rx_wp, rx_rp, tx_wp, tx_rp;
    logic [CW-1:0]    rx_cnt, tx_cnt;
    logic             rx_ovf, tx_ovf;
    logic [LED_W-1:0] led_reg;
    logic [2:0]       irq_en;

    logic        sel, is_wr, is_rd;
    logic [2:0]  off;
    logic        rx_empty, rx_full, tx_empty, tx_full;
    logic        rx_pop, rx_push, rx_ovf_set;
    logic        tx_wr, tx_pop, tx_push, tx_ovf_set;
    logic        st_wr, led_wr, ien_wr;
    logic        tx_idle;
    logic [31:0] be_mask, status, rd_val, rx_cnt32, tx_cnt32;
    logic        unused_ok;

    assign unused_ok = ^{bus.mem_wdata, bus.mem_we};

    // Address decode and FIFO push/pop/overflow decisions for this cycle
    always_comb begin
        sel      = bus.mem_en && (bus.mem_addr[29:3] == BASE_ADDR[31:5]);
        off      = bus.mem_addr[2:0];
        is_wr    = |bus.mem_we;
        is_rd    = sel && !is_wr;
        rx_empty = (rx_cnt == '0);
        rx_full  = (rx_cnt == FULL_CNT);
        tx_empty = (tx_cnt == '0);
        tx_full  = (tx_cnt == FULL_CNT);
        // A DATA read pops only when there is something to pop
        rx_pop     = is_rd && (off == 3'd0) && !rx_empty;
        // A same-cycle pop frees the slot, so a push into a full FIFO still lands
        rx_push    = rx_EN && (!rx_full || rx_pop);
        rx_ovf_set = rx_EN && rx_full && !rx_pop;
        tx_wr      = sel && bus.mem_we[0] && (off == 3'd0);
        // tx_EN gating guarantees at least one idle cycle between send strobes
        tx_pop     = !tx_empty && tx_RDY && !tx_EN;
        tx_push    = tx_wr && (!tx_full || tx_pop);
        tx_ovf_set = tx_wr && tx_full && !tx_pop;
        st_wr      = sel && bus.mem_we[0] && (off == 3'd1);
        led_wr     = sel && is_wr && (off == 3'd2);
        ien_wr     = sel && bus.mem_we[0] && (off == 3'd4);
        tx_idle    = tx_empty && tx_RDY && !tx_EN;
        be_mask    = {{8{bus.mem_we[3]}}, {8{bus.mem_we[2]}},
                      {8{bus.mem_we[1]}}, {8{bus.mem_we[0]}}};
    end

    // Register read mux; the registered copy goes out one cycle later
    always_comb begin
        rx_cnt32 = 32'(rx_cnt);
        tx_cnt32 = 32'(tx_cnt);
        status   = {8'b0, tx_cnt32[7:0], rx_cnt32[7:0], 3'b0,
                    tx_ovf, rx_ovf, tx_idle, !tx_full, !rx_empty};
        rd_val   = '0;
        case (off)
            3'd0:    rd_val = rx_empty ? 32'b0 : {1'b1, 22'b0, rx_mem[rx_rp]};
            3'd1:    rd_val = status;
            3'd2:    rd_val = 32'(led_reg);
            3'd3:    rd_val = 32'(btn);
            3'd4:    rd_val = {29'b0, irq_en};
            default: rd_val = '0;
        endcase
    end

    // FIFO storage; pointers and counts own validity, so no reset is needed here
    always_ff @(posedge CLK) begin
        if (rst_n && rx_push) rx_mem[rx_wp] <= {rx_ERR, rx_D};
        if (rst_n && tx_push) tx_mem[tx_wp] <= bus.mem_wdata[7:0];
    end

    // Control state: pointers, counts, flags, registers, TX strobe, irq and read data
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            rx_wp         <= '0;
            rx_rp         <= '0;
            tx_wp         <= '0;
            tx_rp         <= '0;
            rx_cnt        <= '0;
            tx_cnt        <= '0;
            rx_ovf        <= 1'b0;
            tx_ovf        <= 1'b0;
            led_reg       <= '0;
            irq_en        <= '0;
            irq           <= 1'b0;
            tx_EN         <= 1'b0;
            tx_D          <= '0;
            bus.mem_rdata <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + AW'(1);
            if (rx_pop)  rx_rp <= rx_rp + AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + CW'(1);
                2'b01:   rx_cnt <= rx_cnt - CW'(1);
                default: ;
            endcase

            if (tx_push) tx_wp <= tx_wp + AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + CW'(1);
                2'b01:   tx_cnt <= tx_cnt - CW'(1);
                default: ;
            endcase

            tx_EN <= tx_pop;
            if (tx_pop) tx_D <= tx_mem[tx_rp];

            // Setting wins over a same-cycle write-1-to-clear
            if (rx_ovf_set)                       rx_ovf <= 1'b1;
            else if (st_wr && bus.mem_wdata[3])   rx_ovf <= 1'b0;
            if (tx_ovf_set)                       tx_ovf <= 1'b1;
            else if (st_wr && bus.mem_wdata[4])   tx_ovf <= 1'b0;

            if (led_wr) led_reg <= (led_reg & ~be_mask[LED_W-1:0]) |
                                   (bus.mem_wdata[LED_W-1:0] & be_mask[LED_W-1:0]);
            if (ien_wr) irq_en <= bus.mem_wdata[2:0];

            irq <= (irq_en[0] && !rx_empty) || (irq_en[1] && tx_empty) ||
                   (irq_en[2] && (rx_ovf || tx_ovf));

            bus.mem_rdata <= is_rd ? rd_val : 32'b0;
        end
    end

    assign led = led_reg;
endmodule
